// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU memory bus plus tx/rx byte streams for mem_responder
interface mem_responder_if;
    logic        rdy;
    logic [31:0] mem_a;
    logic [7:0]  mem_write;
    logic        is_write;
    logic [7:0]  mem_result;
    logic        cannot_read;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;
    logic        tx_overflow;

    modport master (
        output rdy, mem_a, mem_write, is_write, tx_ready, rx_data, rx_valid,
        input  mem_result, cannot_read, tx_data, tx_valid, rx_ready, halt, tx_overflow
    );

    modport slave (
        input  rdy, mem_a, mem_write, is_write, tx_ready, rx_data, rx_valid,
        output mem_result, cannot_read, tx_data, tx_valid, rx_ready, halt, tx_overflow
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte RAM plus memory-mapped tx/rx FIFOs and halt flag
module mem_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    logic [7:0]       ram     [2**RAM_AW];
    logic [7:0]       tx_mem  [TX_DEPTH];
    logic [7:0]       rx_mem  [RX_DEPTH];
    logic [TX_AW-1:0] tx_wr, tx_rd;
    logic [TX_AW:0]   tx_count;
    logic [RX_AW-1:0] rx_wr, rx_rd;
    logic [RX_AW:0]   rx_count;

    logic       acc, io_hit, ram_hit, off0, off4;
    logic       tx_full, tx_wr_req, tx_push, tx_pop;
    logic       rx_nonempty, rx_push, rx_pop;
    logic [7:0] rd_byte;

    // rst gates the access so reset discards any RAM write or FIFO push that cycle
    assign acc         = bus.rdy && !rst;
    assign io_hit      = bus.mem_a[17:16] == 2'b11;
    assign ram_hit     = !io_hit && ((bus.mem_a >> RAM_AW) == 32'd0);
    assign off0        = bus.mem_a[15:0] == 16'h0000;
    assign off4        = bus.mem_a[15:0] == 16'h0004;

    assign tx_full     = tx_count == (TX_AW+1)'(TX_DEPTH);
    assign tx_pop      = (tx_count != '0) && bus.tx_ready;
    assign tx_wr_req   = acc && io_hit && bus.is_write && off0;
    // a full FIFO still accepts the byte when the head leaves in the same cycle
    assign tx_push     = tx_wr_req && (!tx_full || tx_pop);

    assign rx_nonempty = rx_count != '0;
    assign rx_push     = bus.rx_valid && bus.rx_ready;
    assign rx_pop      = acc && io_hit && !bus.is_write && off0 && rx_nonempty;

    assign bus.tx_valid = tx_count != '0;
    assign bus.tx_data  = tx_mem[tx_rd];
    assign bus.rx_ready = rx_count != (RX_AW+1)'(RX_DEPTH);

    always_comb begin
        rd_byte = 8'h00;
        if (ram_hit)
            rd_byte = ram[bus.mem_a[RAM_AW-1:0]];
        else if (io_hit && off0 && rx_nonempty)
            rd_byte = rx_mem[rx_rd];
        else if (io_hit && off4)
            rd_byte = {6'b0, rx_nonempty, tx_full};
    end

    always_ff @(posedge clk) begin
        if (acc && bus.is_write && ram_hit)
            ram[bus.mem_a[RAM_AW-1:0]] <= bus.mem_write;
        if (tx_push)
            tx_mem[tx_wr] <= bus.mem_write;
        if (rx_push)
            rx_mem[rx_wr] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_result  <= 8'h00;
            bus.cannot_read <= 1'b0;
            bus.halt        <= 1'b0;
            bus.tx_overflow <= 1'b0;
            tx_wr           <= '0;
            tx_rd           <= '0;
            tx_count        <= '0;
            rx_wr           <= '0;
            rx_rd           <= '0;
            rx_count        <= '0;
        end else begin
            if (acc && !bus.is_write)
                bus.mem_result <= rd_byte;
            bus.cannot_read <= tx_count >= (TX_AW+1)'(TX_DEPTH - 2);
            if (tx_wr_req && tx_full && !tx_pop)
                bus.tx_overflow <= 1'b1;
            if (acc && io_hit && bus.is_write && off4)
                bus.halt <= 1'b1;

            if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
                2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
                default: tx_count <= tx_count;
            endcase

            if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
                2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed vector bench for mem_responder
module tb_mem_responder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_responder_if bus ();

    mem_responder #(.RAM_AW(17), .TX_DEPTH(16), .RX_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rdy;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cpu(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
        bus.rdy       = r;
        bus.is_write  = w;
        bus.mem_a     = a;
        bus.mem_write = d;
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.rdy = 1'b0; bus.is_write = 1'b0; bus.mem_a = '0; bus.mem_write = '0;
        bus.tx_ready = 1'b0; bus.rx_data = '0; bus.rx_valid = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 32'h00100, 8'hA5, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 32'h00100, 8'h00, 1'b1, 8'hA5};
        vecs[2]  = '{1'b1, 1'b1, 32'h1FFFF, 8'h3C, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 32'h1FFFF, 8'h00, 1'b1, 8'h3C};
        vecs[4]  = '{1'b1, 1'b1, 32'h20000, 8'h77, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 32'h20000, 8'h00, 1'b1, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 32'h00200, 8'h11, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 32'h00200, 8'h22, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 32'h00200, 8'h00, 1'b1, 8'h11};
        vecs[9]  = '{1'b0, 1'b0, 32'h00100, 8'h00, 1'b1, 8'h11};
        vecs[10] = '{1'b1, 1'b0, 32'h40100, 8'h00, 1'b1, 8'h00};
        vecs[11] = '{1'b1, 1'b1, 32'h10100, 8'h5A, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 32'h10100, 8'h00, 1'b1, 8'h5A};
        vecs[13] = '{1'b1, 1'b0, 32'h30008, 8'h00, 1'b1, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 32'h30004, 8'h00, 1'b1, 8'h00};
        vecs[15] = '{1'b1, 1'b0, 32'h00100, 8'h00, 1'b1, 8'hA5};

        step();
        step();
        chk("rst_mem_result", bus.mem_result, 8'h00);
        chk("rst_cannot_read", bus.cannot_read, 1'b0);
        chk("rst_halt", bus.halt, 1'b0);
        chk("rst_tx_overflow", bus.tx_overflow, 1'b0);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_rx_ready", bus.rx_ready, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cpu(vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk)
                chk($sformatf("vec%0d_mem_result", i), bus.mem_result, vecs[i].exp);
        end

        // rx single byte, status, pop, empty pop
        bus.rx_data = 8'h55; bus.rx_valid = 1'b1;
        cpu(1'b0, 1'b0, 32'h0, 8'h00);
        bus.rx_valid = 1'b0;
        cpu(1'b1, 1'b0, 32'h30004, 8'h00);
        chk("rx_status", bus.mem_result, 8'h02);
        cpu(1'b1, 1'b0, 32'h30000, 8'h00);
        chk("rx_pop_55", bus.mem_result, 8'h55);
        cpu(1'b1, 1'b0, 32'h30000, 8'h00);
        chk("rx_pop_empty", bus.mem_result, 8'h00);

        // rx fill to depth, extra byte refused, drain in order
        for (int i = 0; i < 8; i++) begin
            bus.rx_data = 8'h80 + 8'(i); bus.rx_valid = 1'b1;
            cpu(1'b0, 1'b0, 32'h0, 8'h00);
        end
        chk("rx_full_ready", bus.rx_ready, 1'b0);
        bus.rx_data = 8'hAA;
        cpu(1'b0, 1'b0, 32'h0, 8'h00);
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cpu(1'b1, 1'b0, 32'h30000, 8'h00);
            chk($sformatf("rx_drain%0d", i), bus.mem_result, 8'h80 + 8'(i));
        end
        chk("rx_drained_ready", bus.rx_ready, 1'b1);

        // tx ordering; rdy=0 write must not push
        cpu(1'b0, 1'b1, 32'h30000, 8'h99);
        chk("tx_rdy0_no_push", bus.tx_valid, 1'b0);
        cpu(1'b1, 1'b1, 32'h30000, 8'h41);
        cpu(1'b1, 1'b1, 32'h30000, 8'h42);
        bus.rdy = 1'b0; bus.tx_ready = 1'b1;
        chk("tx_first_valid", bus.tx_valid, 1'b1);
        chk("tx_first_data", bus.tx_data, 8'h41);
        step();
        chk("tx_second_data", bus.tx_data, 8'h42);
        step();
        chk("tx_empty_valid", bus.tx_valid, 1'b0);
        bus.tx_ready = 1'b0;

        // tx fill, cannot_read threshold, overflow, push-with-pop when full
        for (int i = 0; i < 14; i++)
            cpu(1'b1, 1'b1, 32'h30000, 8'(i));
        cpu(1'b0, 1'b0, 32'h0, 8'h00);
        chk("tx_cannot_read", bus.cannot_read, 1'b1);
        cpu(1'b1, 1'b1, 32'h30000, 8'd14);
        cpu(1'b1, 1'b1, 32'h30000, 8'd15);
        chk("tx_no_overflow_yet", bus.tx_overflow, 1'b0);
        cpu(1'b1, 1'b0, 32'h30004, 8'h00);
        chk("tx_full_status", bus.mem_result, 8'h01);
        cpu(1'b1, 1'b1, 32'h30000, 8'hFF);
        chk("tx_overflow", bus.tx_overflow, 1'b1);
        bus.tx_ready = 1'b1;
        cpu(1'b1, 1'b1, 32'h30000, 8'hEE);
        bus.rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_drain%0d_valid", i), bus.tx_valid, 1'b1);
            chk($sformatf("tx_drain%0d_data", i), bus.tx_data, (i < 15) ? 8'(i + 1) : 8'hEE);
            step();
        end
        chk("tx_drained_valid", bus.tx_valid, 1'b0);
        step();
        chk("tx_drained_cannot_read", bus.cannot_read, 1'b0);
        bus.tx_ready = 1'b0;

        // halt ignores rdy=0, then sticks
        cpu(1'b0, 1'b1, 32'h30004, 8'h00);
        chk("halt_rdy0", bus.halt, 1'b0);
        cpu(1'b1, 1'b1, 32'h30004, 8'h00);
        chk("halt_set", bus.halt, 1'b1);
        cpu(1'b0, 1'b0, 32'h0, 8'h00);
        cpu(1'b0, 1'b0, 32'h0, 8'h00);
        chk("halt_sticky", bus.halt, 1'b1);

        // reset mid-operation with 5 bytes queued; same-cycle RAM write discarded
        for (int i = 0; i < 5; i++)
            cpu(1'b1, 1'b1, 32'h30000, 8'h60 + 8'(i));
        chk("pre_rst_tx_valid", bus.tx_valid, 1'b1);
        rst = 1'b1;
        cpu(1'b1, 1'b1, 32'h00100, 8'h99);
        chk("mid_rst_tx_valid", bus.tx_valid, 1'b0);
        chk("mid_rst_cannot_read", bus.cannot_read, 1'b0);
        chk("mid_rst_halt", bus.halt, 1'b0);
        chk("mid_rst_tx_overflow", bus.tx_overflow, 1'b0);
        chk("mid_rst_mem_result", bus.mem_result, 8'h00);
        rst = 1'b0;
        cpu(1'b1, 1'b0, 32'h00100, 8'h00);
        chk("ram_kept_after_rst", bus.mem_result, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_AW, default 17, meaning RAM byte-address width; RAM spans 0x00000..2^RAM_AW-1.
REQ-002 Parameter TX_DEPTH, default 16, meaning tx FIFO entries (power of 2, >=4).
REQ-003 Parameter RX_DEPTH, default 8, meaning rx FIFO entries (power of 2, >=2).
REQ-004 clk  in  1  sole clock; all state on posedge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 rdy  in  1  CPU-side enable; low freezes CPU-side accesses.
REQ-007 mem_a  in  32  byte address from memory controller.
REQ-008 mem_write  in  8  write byte.
REQ-009 is_write  in  1  1 = write mem_write at mem_a; 0 = read.
REQ-010 mem_result  out  8  registered read byte.
REQ-011 cannot_read  out  1  IO buffer nearly full; controller stalls IO accesses.
REQ-012 tx_data  out  8 / tx_valid  out  1 / tx_ready  in  1  byte-stream output, valid/ready.
REQ-013 rx_data  in  8 / rx_valid  in  1 / rx_ready  out  1  byte-stream input, valid/ready.
REQ-014 halt  out  1  sticky program-end flag.
REQ-015 tx_overflow  out  1  sticky, tx byte dropped.

Function
REQ-016 IO region = mem_a[17:16]==2'b11; RAM region = mem_a[17:16]!=2'b11 and mem_a < 2^RAM_AW; all else unmapped.
REQ-017 Access occurs on a posedge only when rdy=1 and rst=0; rdy=0 -> no RAM write, no FIFO push/pop from CPU side, mem_result held.
REQ-018 RAM write: byte stored at mem_a[RAM_AW-1:0] at that posedge.
REQ-019 RAM read: mem_result = RAM[mem_a] registered, valid cycle after address (1-cycle latency); read-after-write same address next cycle returns new byte.
REQ-020 Unmapped: reads return 0x00, writes ignored.
REQ-021 IO write 0x30000: push mem_write into tx FIFO; if full, byte dropped and tx_overflow set.
REQ-022 IO write 0x30004: halt set to 1 (sticky until reset).
REQ-023 IO read 0x30000: mem_result = rx FIFO head and pop; empty -> 0x00, no pop.
REQ-024 IO read 0x30004: mem_result = {6'b0, rx_nonempty, tx_full}; no side effects.
REQ-025 Other IO offsets: read 0x00, write ignored.
REQ-026 tx FIFO: tx_valid = count!=0; tx_data = head (combinational); pop on tx_valid&&tx_ready, independent of rdy.
REQ-027 Simultaneous CPU push and tx pop: both occur, count unchanged; push when full with pop same cycle accepted.
REQ-028 cannot_read = registered (tx_count >= TX_DEPTH-2); covers one in-flight write after assertion.
REQ-029 rx FIFO: rx_ready = rx_count!=RX_DEPTH; push on rx_valid&&rx_ready, independent of rdy; simultaneous push/pop keeps count.
REQ-030 Pointers wrap modulo depth; count width log2(depth)+1.
REQ-031 No combinational path from mem_a/is_write to any output.

Reset
REQ-032 On rst at posedge: mem_result=0, cannot_read=0, halt=0, tx_overflow=0, both FIFOs empty (tx_valid=0, rx_ready=1); RAM contents not cleared.
REQ-033 rst mid-operation discards FIFO contents and any access that cycle; rst has priority over rdy.

Verification
REQ-034 Write 0xA5 to 0x00100, read 0x00100 next cycle -> mem_result=0xA5 one cycle after read address.
REQ-035 tx_ready=0, 14 writes to 0x30000 with TX_DEPTH=16 -> cannot_read=1 cycle after 14th; 17th write -> tx_overflow=1, count 16.
REQ-036 Push 0x41,0x42 to tx, tx_ready=1 -> tx_data 0x41 then 0x42 on consecutive cycles, tx_valid then 0.
REQ-037 rx_valid with 0x55 then IO read 0x30004 -> 0x02; read 0x30000 -> 0x55; read 0x30000 again -> 0x00.
REQ-038 rdy=0 during write to 0x00200 -> RAM unchanged; write to 0x30004 -> halt=1 until rst.
REQ-039 rst asserted with 5 bytes queued -> next cycle tx_valid=0, cannot_read=0, previously written RAM byte still reads back.
